// File: rtl/mem_bist_ctrl.sv
// Two-pass memory BIST controller: write/read a background pattern, then write/read its inverse.
// Define MEM_BIST_ERR_LOG_EN to enable the first-failure capture and error counter.
module mem_bist_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              en,
  output logic              wr0,
  output logic              wr1,
  output logic [ADDR_W-1:0] add0,
  output logic [ADDR_W-1:0] add1,
  output logic [DATA_W-1:0] data0_in,
  output logic [DATA_W-1:0] data1_in,
  input  logic [DATA_W-1:0] data0_out,
  input  logic [DATA_W-1:0] data1_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [6:0]        err_count
);

  typedef enum logic [2:0] {IDLE, W_BG, R_BG, W_INV, R_INV, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, next;
  logic [ADDR_W-1:0] cnt;
  logic              drain;
  logic [DATA_W-1:0] pat;
  logic              accept;
  logic              rd_issue;
  logic              rd_valid;
  logic              rd_port1;
  logic [DATA_W-1:0] rd_exp;
  logic [DATA_W-1:0] rd_data;
  logic              mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next     = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wr0      = 1'b1;
    wr1      = 1'b1;
    add0     = '0;
    add1     = '0;
    data0_in = '0;
    data1_in = '0;
    rd_issue = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next   = W_BG;
          accept = 1'b1;
        end
      end
      W_BG: begin
        busy     = 1'b1;
        wr0      = 1'b0;
        add0     = cnt;
        data0_in = pat;
        if (cnt == LAST) next = R_BG;
      end
      R_BG: begin
        busy     = 1'b1;
        add1     = cnt;
        rd_issue = !drain;
        if (drain) next = W_INV;
      end
      W_INV: begin
        busy     = 1'b1;
        wr1      = 1'b0;
        add1     = cnt;
        data1_in = ~pat;
        if (cnt == '0) next = R_INV;
      end
      R_INV: begin
        busy     = 1'b1;
        add0     = cnt;
        rd_issue = !drain;
        if (drain) next = DONE;
      end
      DONE: begin
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
    en = busy;
  end

  // Read phases end with one drain cycle so the last read's data can still be compared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      drain <= 1'b0;
    end else begin
      case (state)
        W_BG: cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        R_BG: begin
          if (drain) begin
            drain <= 1'b0;
            cnt   <= LAST;
          end else if (cnt == LAST) drain <= 1'b1;
          else cnt <= cnt + 1'b1;
        end
        W_INV: cnt <= (cnt == '0) ? LAST : cnt - 1'b1;
        R_INV: begin
          if (drain) begin
            drain <= 1'b0;
            cnt   <= '0;
          end else if (cnt == '0) drain <= 1'b1;
          else cnt <= cnt - 1'b1;
        end
        default: begin
          cnt   <= '0;
          drain <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat      <= '0;
      pass     <= 1'b0;
      rd_valid <= 1'b0;
      rd_port1 <= 1'b0;
      rd_exp   <= '0;
    end else begin
      rd_valid <= rd_issue;
      rd_port1 <= (state == R_BG);
      rd_exp   <= (state == R_INV) ? ~pat : pat;
      if (accept) begin
        pat  <= pattern;
        pass <= 1'b1;
      end else if (mismatch) begin
        pass <= 1'b0;
      end
    end
  end

  assign rd_data  = rd_port1 ? data1_out : data0_out;
  assign mismatch = rd_valid && (rd_data != rd_exp);

`ifdef MEM_BIST_ERR_LOG_EN
  logic [ADDR_W-1:0] rd_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr   <= '0;
      fail_addr <= '0;
      fail_data <= '0;
      err_count <= '0;
    end else begin
      rd_addr <= cnt;
      if (accept) begin
        fail_addr <= '0;
        fail_data <= '0;
        err_count <= '0;
      end else if (mismatch) begin
        if (err_count == '0) begin
          fail_addr <= rd_addr;
          fail_data <= rd_data;
        end
        if (err_count != 7'h7F) err_count <= err_count + 7'd1;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Self-checking bench for mem_bist_ctrl: dual-port memory model with fault injection,
// table-driven and randomized runs checked against a run-level reference model.
module tb_mem_bist_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int RUN   = 258;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          en, wr0, wr1, busy, done, pass;
  logic [AW-1:0] add0, add1, fail_addr;
  logic [DW-1:0] data0_in, data1_in, fail_data;
  logic [DW-1:0] data0_out = '0;
  logic [DW-1:0] data1_out = '0;
  logic [6:0]    err_count;

  int errors = 0;
  int checks = 0;

  mem_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern),
    .en(en), .wr0(wr0), .wr1(wr1), .add0(add0), .add1(add1),
    .data0_in(data0_in), .data1_in(data1_in),
    .data0_out(data0_out), .data1_out(data1_out),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Memory model with registered reads; fault masks corrupt read data per port.
  logic [DW-1:0] mem       [DEPTH];
  logic [DW-1:0] fault_bg  [DEPTH];
  logic [DW-1:0] fault_inv [DEPTH];
  logic          scramble = 1'b0;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'($urandom);
    end else if (en) begin
      if (!wr0) mem[add0] <= data0_in;
      else      data0_out <= mem[add0] ^ fault_inv[add0];
      if (!wr1) mem[add1] <= data1_in;
      else      data1_out <= mem[add1] ^ fault_bg[add1];
    end
  end

  typedef struct {
    logic [7:0] pat;
    int         phase;
    int         addr;
    logic [7:0] mask;
    logic       exp_pass;
    logic [5:0] exp_fa;
    logic [7:0] exp_fd;
    logic [6:0] exp_ec;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearFaults();
    for (int i = 0; i < DEPTH; i++) begin
      fault_bg[i]  = '0;
      fault_inv[i] = '0;
    end
  endtask

  // Run outcome from the rules: reads ascend in the background pass, descend in the inverse pass.
  task automatic modelRun(input logic [7:0] p, output logic ep, output logic [5:0] fa,
                          output logic [7:0] fd, output logic [6:0] ec);
    int n;
    n  = 0;
    fa = '0;
    fd = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (fault_bg[a] != 0) begin
        if (n == 0) begin
          fa = 6'(a);
          fd = p ^ fault_bg[a];
        end
        n++;
      end
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      if (fault_inv[a] != 0) begin
        if (n == 0) begin
          fa = 6'(a);
          fd = ~p ^ fault_inv[a];
        end
        n++;
      end
    end
    ep = (n == 0);
    ec = (n > 127) ? 7'd127 : 7'(n);
  endtask

  function automatic int phaseOf(input int k);
    if (k < 64)       return 0;
    else if (k < 128) return 1;
    else if (k == 128) return 2;
    else if (k < 193) return 3;
    else if (k < 257) return 4;
    else              return 5;
  endfunction

  function automatic logic [18:0] expCycle(input int k, input logic [7:0] p);
    case (phaseOf(k))
      0:       return {5'b11001, 6'(k), p};
      1:       return {5'b11011, 6'(k - 64), 8'h00};
      3:       return {5'b11010, 6'(63 - (k - 129)), ~p};
      4:       return {5'b11011, 6'(63 - (k - 193)), 8'h00};
      default: return {5'b11011, 6'h00, 8'h00};
    endcase
  endfunction

  function automatic logic [18:0] actCycle(input int k);
    logic [4:0] ctl;
    ctl = {en, busy, done, wr0, wr1};
    case (phaseOf(k))
      0:       return {ctl, add0, data0_in};
      1:       return {ctl, add1, 8'h00};
      3:       return {ctl, add1, data1_in};
      4:       return {ctl, add0, 8'h00};
      default: return {ctl, 6'h00, 8'h00};
    endcase
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, " idle ctl"}, {en, busy, done, wr0, wr1}, 5'b00011);
    checkOutput({tag, " idle bus"}, {add0, add1, data0_in, data1_in}, 28'h0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " ctl"}, {en, busy, done, pass, wr0, wr1}, 6'b000011);
    checkOutput({tag, " bus"}, {add0, add1, data0_in, data1_in}, 28'h0);
    checkOutput({tag, " log"}, {fail_addr, fail_data, err_count}, 21'h0);
  endtask

  // One full run: every busy cycle is checked, then the DONE cycle and the return to IDLE.
  task automatic applyStimulus(input logic [7:0] p, input bit hold, input string tag,
                               input logic ep, input logic [5:0] fa, input logic [7:0] fd,
                               input logic [6:0] ec);
`ifndef MEM_BIST_ERR_LOG_EN
    fa = '0;
    fd = '0;
    ec = '0;
`endif
    @(negedge clk);
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    start    = 1'b1;
    pattern  = p;
    @(negedge clk);
    if (!hold) start = 1'b0;
    pattern = ~p;
    for (int k = 0; k < RUN; k++) begin
      checkOutput($sformatf("%s cyc%0d", tag, k), 32'(actCycle(k)), 32'(expCycle(k, p)));
      @(negedge clk);
    end
    checkOutput({tag, " done ctl"}, {en, busy, done, wr0, wr1}, 5'b00111);
    checkOutput({tag, " pass"}, pass, ep);
    checkOutput({tag, " fail_addr"}, fail_addr, fa);
    checkOutput({tag, " fail_data"}, fail_data, fd);
    checkOutput({tag, " err_count"}, err_count, ec);
    @(negedge clk);
    checkIdle(tag);
    checkOutput({tag, " pass held"}, pass, ep);
  endtask

  initial begin
    logic       ep;
    logic [5:0] fa;
    logic [7:0] fd;
    logic [6:0] ec;
    int         n;

    vecs[0] = '{8'hA5, 0, 0,  8'h00, 1'b1, 6'd0,  8'h00, 7'd0};
    vecs[1] = '{8'hA5, 1, 5,  8'h01, 1'b0, 6'd5,  8'hA4, 7'd1};
    vecs[2] = '{8'h00, 0, 0,  8'h00, 1'b1, 6'd0,  8'h00, 7'd0};
    vecs[3] = '{8'h3C, 2, 10, 8'h80, 1'b0, 6'd10, 8'h43, 7'd1};
    vecs[4] = '{8'hFF, 1, 63, 8'hFF, 1'b0, 6'd63, 8'h00, 7'd1};
    vecs[5] = '{8'h5A, 2, 0,  8'h0F, 1'b0, 6'd0,  8'hAA, 7'd1};

    clearFaults();
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b1;
    @(negedge clk);
    checkIdle("post-reset");

    for (int v = 0; v < 6; v++) begin
      clearFaults();
      if (vecs[v].phase == 1) fault_bg[vecs[v].addr] = vecs[v].mask;
      if (vecs[v].phase == 2) fault_inv[vecs[v].addr] = vecs[v].mask;
      applyStimulus(vecs[v].pat, 1'b0, $sformatf("vec%0d", v),
                    vecs[v].exp_pass, vecs[v].exp_fa, vecs[v].exp_fd, vecs[v].exp_ec);
    end

    for (int r = 0; r < 8; r++) begin
      logic [7:0] p;
      clearFaults();
      p = 8'($urandom);
      n = $urandom_range(0, 3);
      for (int f = 0; f < n; f++) begin
        if ($urandom_range(0, 1) == 1) fault_bg[$urandom_range(0, 63)] = 8'($urandom_range(1, 255));
        else                           fault_inv[$urandom_range(0, 63)] = 8'($urandom_range(1, 255));
      end
      modelRun(p, ep, fa, fd, ec);
      applyStimulus(p, 1'b0, $sformatf("rand%0d", r), ep, fa, fd, ec);
    end

    for (int i = 0; i < DEPTH; i++) begin
      fault_bg[i]  = 8'($urandom_range(1, 255));
      fault_inv[i] = 8'($urandom_range(1, 255));
    end
    modelRun(8'h96, ep, fa, fd, ec);
    applyStimulus(8'h96, 1'b0, "saturate", ep, fa, fd, ec);

    // Reset in cycle 10 of the background read pass must abort cleanly.
    clearFaults();
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (74) @(negedge clk);
    rst = 1'b0;
    #1;
    checkReset("mid-run reset");
    @(negedge clk);
    checkOutput("reset en low", en, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no resume", {en, busy, done}, 3'b000);
    applyStimulus(8'hC3, 1'b0, "after-reset", 1'b1, 6'd0, 8'h00, 7'd0);

    // start held through a run: one done, then a fresh run from IDLE.
    applyStimulus(8'h5A, 1'b1, "held", 1'b1, 6'd0, 8'h00, 7'd0);
    @(negedge clk);
    checkOutput("held restart busy", {busy, done}, 2'b10);
    start = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held second run length", n, RUN);
    checkOutput("held second run pass", pass, 1'b1);
    @(negedge clk);
    checkIdle("held end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
